// File: rtl/tx_frame_scheduler.sv
`timescale 1ns/1ps
// Frame sequencer for the PCM -> Hamming(7,4) -> FSK transmit chain.
// Repeats SAMPLE, ENCODE (two nibbles), SEND (14 bit periods) until stopped.
module tx_frame_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cfg_div,
  input  logic        cfg_load,
  output logic        cfg_ack,
  output logic        cfg_err,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        sample_en,
  output logic        enc_en,
  output logic        nib_sel,
  output logic        bit_en,
  output logic [3:0]  bit_idx,
  output logic        frame_done
);

  localparam logic [1:0]  IDLE   = 2'd0;
  localparam logic [1:0]  SAMPLE = 2'd1;
  localparam logic [1:0]  ENCODE = 2'd2;
  localparam logic [1:0]  SEND   = 2'd3;

  localparam logic [15:0] DIV_RESET = 16'd4;
  localparam logic [15:0] DIV_MIN   = 16'd2;
  localparam logic [3:0]  LAST_BIT  = 4'd13;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] div_reg;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [3:0]  idx_nxt;
  logic        nib_nxt;
  logic        stop_pending;
  logic        stop_pending_nxt;
  logic        period_end;
  logic        cfg_ok;

  assign period_end = (cnt == div_reg - 16'd1);
  assign cfg_ok     = cfg_load && (state == IDLE) && (cfg_div >= DIV_MIN);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    idx_nxt   = '0;
    nib_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        state_nxt = ENCODE;
      end
      ENCODE: begin
        // nib_sel doubles as the phase bit of the two-cycle encode window
        if (!nib_sel) nib_nxt = 1'b1;
        else          state_nxt = SEND;
      end
      SEND: begin
        if (period_end) begin
          if (bit_idx == LAST_BIT) state_nxt = (stop_pending || stop) ? IDLE : SAMPLE;
          else                     idx_nxt   = bit_idx + 4'd1;
        end else begin
          cnt_nxt = cnt + 16'd1;
          idx_nxt = bit_idx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stop_pending_nxt = stop_pending;
    if (state_nxt == IDLE)             stop_pending_nxt = 1'b0;
    else if (state != IDLE && stop)    stop_pending_nxt = 1'b1;
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      div_reg      <= DIV_RESET;
      cnt          <= '0;
      stop_pending <= 1'b0;
      cfg_ack      <= 1'b0;
      cfg_err      <= 1'b0;
      busy         <= 1'b0;
      sample_en    <= 1'b0;
      enc_en       <= 1'b0;
      nib_sel      <= 1'b0;
      bit_en       <= 1'b0;
      bit_idx      <= '0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      stop_pending <= stop_pending_nxt;
      cfg_ack      <= cfg_ok;
      cfg_err      <= cfg_load && !cfg_ok;
      if (cfg_ok) div_reg <= cfg_div;
      busy         <= (state_nxt != IDLE);
      sample_en    <= (state_nxt == SAMPLE);
      enc_en       <= (state_nxt == ENCODE);
      nib_sel      <= nib_nxt;
      bit_en       <= (state_nxt == SEND) && (cnt_nxt == 16'd0);
      bit_idx      <= idx_nxt;
      frame_done   <= (state_nxt == SEND) && (idx_nxt == LAST_BIT) &&
                      (cnt_nxt == div_reg - 16'd1);
    end
  end

endmodule

// File: doc/tx_frame_scheduler.md
TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: cfg_div  input  16  requested bit period in clk cycles.
REQ-004 SHALL have port: cfg_load  input  1  one-cycle request to apply cfg_div.
REQ-005 SHALL have port: cfg_ack  output  1  one-cycle pulse: cfg_div accepted.
REQ-006 SHALL have port: cfg_err  output  1  one-cycle pulse: cfg_load rejected.
REQ-007 SHALL have port: start  input  1  one-cycle request to begin continuous framing.
REQ-008 SHALL have port: stop  input  1  one-cycle request to end framing after current frame.
REQ-009 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port: sample_en  output  1  PCM sampler strobe.
REQ-011 SHALL have port: enc_en  output  1  Hamming(7,4) encoder strobe.
REQ-012 SHALL have port: nib_sel  output  1  nibble being encoded: 0 = low, 1 = high.
REQ-013 SHALL have port: bit_en  output  1  FSK modulator strobe, first cycle of each bit period.
REQ-014 SHALL have port: bit_idx  output  4  codeword bit index in transmission, 0..13.
REQ-015 SHALL have port: frame_done  output  1  one-cycle pulse on last cycle of a frame.

Function
REQ-016 SHALL implement states IDLE, SAMPLE, ENCODE, SEND; all outputs registered and reflecting the current state.
REQ-017 SHALL hold internal period register div_reg (16 bit), reset value 4.
REQ-018 SHALL, on cfg_load in IDLE with cfg_div >= 2, load div_reg and pulse cfg_ack the next cycle.
REQ-019 SHALL, on cfg_load with cfg_div < 2 or in any state other than IDLE, leave div_reg unchanged and pulse cfg_err the next cycle.
REQ-020 SHALL, on start in IDLE without stop, enter SAMPLE the next cycle; start while busy is ignored.
REQ-021 SHALL, when start and stop coincide in IDLE, remain in IDLE.
REQ-022 SHALL stay in SAMPLE exactly 1 cycle with sample_en = 1, then enter ENCODE.
REQ-023 SHALL stay in ENCODE exactly 2 cycles with enc_en = 1, nib_sel = 0 on first and 1 on second, then enter SEND.
REQ-024 SHALL in SEND step bit_idx 0..13, each value held exactly div_reg cycles; bit_en = 1 only on the first cycle of each value.
REQ-025 SHALL pulse frame_done on the final cycle of bit_idx 13.
REQ-026 SHALL, after bit_idx 13, enter SAMPLE if no stop pending, else IDLE; frame length = 3 + 14*div_reg cycles.
REQ-027 SHALL latch stop received in any busy state as stop_pending; clear it on entry to IDLE; the frame in progress always completes.
REQ-028 SHALL ignore stop in IDLE except per REQ-021.
REQ-029 SHALL keep sample_en, enc_en, bit_en, frame_done, cfg_ack, cfg_err at 0 outside the conditions above; nib_sel = 0 outside ENCODE; bit_idx = 0 outside SEND.
REQ-030 SHALL use a period counter of 16 bits counting 0..div_reg-1; div_reg is stable while busy (REQ-019).

Reset
REQ-031 SHALL on reset, at any time including mid-frame, go to IDLE immediately, div_reg = 4, stop_pending = 0, and all outputs 0.
REQ-032 SHALL begin normal operation on the first clk edge after reset deasserts; no output pulse is generated by reset release.

Verification
REQ-033 SHALL cover: reset, start pulse, no cfg -> sample_en cycle 1, enc_en cycles 2-3, bit_en every 4 cycles, frame_done at cycle 59, next sample_en cycle 60.
REQ-034 SHALL cover: cfg_div=10, cfg_load in IDLE -> cfg_ack next cycle; start -> each bit_idx held 10 cycles, frame 143 cycles.
REQ-035 SHALL cover: cfg_div=1 in IDLE, then cfg_div=8 during SEND -> cfg_err both times, div_reg stays 4.
REQ-036 SHALL cover: stop during bit_idx 5 of frame 1 -> frame 1 completes with frame_done, busy falls next cycle, no sample_en follows.
REQ-037 SHALL cover: start and stop same cycle in IDLE -> busy stays 0; start during SEND -> no effect on timing.
REQ-038 SHALL cover: reset asserted during ENCODE -> busy, enc_en, nib_sel, bit_idx all 0 immediately; after release, start -> full 59-cycle frame.
